// File: rtl/txuart_pkg.sv
// txuart_pkg: shared definitions for the configurable UART transmitter.
//   state_t     - transmitter FSM state encoding
//   PAR_*       - parity mode constants for the PARITY parameter
//   frame_bits  - total bits on the line per frame
//   parity_bit  - parity bit over a zero-padded payload
package txuart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CTS = 3'd1,
    START    = 3'd2,
    DATA     = 3'd3,
    PARITY   = 3'd4,
    STOP     = 3'd5,
    BREAK    = 3'd6
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Start bit + payload + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

  // Payload must be zero-padded above the active data bits so they do not
  // disturb the reduction.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/txuart_baud.sv
// txuart_baud: bit-period timer for the UART transmitter.
//   i_clk     - system clock
//   i_reset   - asynchronous active-high reset
//   i_restart - reload for a new bit period (takes priority)
//   i_run     - counter active; held at zero when low
//   o_stb     - high during the last cycle of each bit period
module txuart_baud
  import txuart_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd139
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_restart,
  input  logic i_run,
  output logic o_stb
);

  logic [23:0] cnt_r;

  // Down-counter: loads on each bit start, strobe fires when it reaches zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_r <= 24'd0;
    end else if (i_restart) begin
      cnt_r <= CLOCKS_PER_BAUD - 24'd1;
    end else if (!i_run) begin
      cnt_r <= 24'd0;
    end else if (cnt_r != 24'd0) begin
      cnt_r <= cnt_r - 24'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign o_stb = i_run && (cnt_r == 24'd0);

endmodule

// File: rtl/txuart_cfg.sv
// txuart_cfg: parametrised UART transmitter with CTS flow control.
// Optional feature: define TXUART_BREAK_EN to add the i_break port and the
// BREAK state (line held low, then STOP_BITS periods of mark-after-break).
//   i_clk     - system clock
//   i_reset   - asynchronous active-high reset
//   i_wr      - write strobe, accepted only while o_busy is low
//   i_data    - payload, sampled on acceptance
//   i_cts_n   - clear-to-send, active low, asynchronous
//   i_break   - break request (TXUART_BREAK_EN only)
//   o_busy    - frame pending or in progress
//   o_uart_tx - registered serial line, LSB first, idles high
module txuart_cfg
  import txuart_pkg::*;
#(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd139,
  parameter int          DATA_BITS       = 8,
  parameter int          PARITY          = 0,
  parameter int          STOP_BITS       = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_cts_n,
`ifdef TXUART_BREAK_EN
  input  logic                 i_break,
`endif
  output logic                 o_busy,
  output logic                 o_uart_tx
);

  localparam int         FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam logic [2:0] LAST_DATA  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP  = 3'(STOP_BITS - 1);
  localparam bit         HAS_PARITY = (PARITY != PAR_NONE);

  if (CLOCKS_PER_BAUD < 24'd2) begin : g_bad_baud
    $error("txuart_cfg: CLOCKS_PER_BAUD must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("txuart_cfg: DATA_BITS must be 5..8");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("txuart_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("txuart_cfg: STOP_BITS must be 1 or 2");
  end
  if (FRAME_BITS < 7 || FRAME_BITS > 12) begin : g_bad_frame
    $error("txuart_cfg: frame length out of range");
  end

  state_t                 state_r;
  logic                   tx_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   par_r;
  logic [2:0]             bit_cnt_r;
  logic [1:0]             cts_sync_r;
  logic [7:0]             data_pad_s;
  logic                   cts_ok_s;
  logic                   break_req_s;
  logic                   stb_s;
  logic                   run_s;
  logic                   last_stop_s;
  logic                   busy_s;
  logic                   accept_s;
  logic                   restart_s;

`ifdef TXUART_BREAK_EN
  assign break_req_s = i_break;
`else
  assign break_req_s = 1'b0;
`endif

  // Zero-pad the payload so the parity helper sees only active data bits.
  always_comb begin
    data_pad_s = 8'd0;
    data_pad_s[DATA_BITS-1:0] = i_data;
  end

  // Two-flop synchroniser for CTS; resets to "not clear".
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cts_sync_r <= 2'b11;
    end else begin
      cts_sync_r <= {cts_sync_r[0], i_cts_n};
    end
  end

  assign cts_ok_s = ~cts_sync_r[1];
  assign run_s    = (state_r == START) || (state_r == DATA) ||
                    (state_r == txuart_pkg::PARITY) || (state_r == STOP);

  // Busy drops in the final cycle of the last stop bit so a queued write can
  // follow with no idle gap.
  assign last_stop_s = (state_r == STOP) && (bit_cnt_r == LAST_STOP) && stb_s;
  assign busy_s      = (state_r != IDLE) && !last_stop_s;
  assign accept_s    = i_wr && !busy_s && !((state_r == IDLE) && break_req_s);
  assign restart_s   = stb_s || (accept_s && cts_ok_s) ||
                       ((state_r == WAIT_CTS) && cts_ok_s) ||
                       ((state_r == BREAK) && !break_req_s);

  txuart_baud #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_baud (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_restart (restart_s),
    .i_run     (run_s),
    .o_stb     (stb_s)
  );

  // Transmit FSM: owns the line register, shift register and bit counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= IDLE;
      tx_r      <= 1'b1;
      shift_r   <= '0;
      par_r     <= 1'b0;
      bit_cnt_r <= 3'd0;
    end else if (accept_s) begin
      shift_r   <= i_data;
      par_r     <= parity_bit(data_pad_s, PARITY);
      bit_cnt_r <= 3'd0;
      if (cts_ok_s) begin
        state_r <= START;
        tx_r    <= 1'b0;
      end else begin
        state_r <= WAIT_CTS;
        tx_r    <= 1'b1;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (break_req_s) begin
            state_r <= BREAK;
            tx_r    <= 1'b0;
          end
        end
        WAIT_CTS: begin
          if (cts_ok_s) begin
            state_r <= START;
            tx_r    <= 1'b0;
          end
        end
        START: begin
          if (stb_s) begin
            state_r   <= DATA;
            tx_r      <= shift_r[0];
            shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
            bit_cnt_r <= 3'd0;
          end
        end
        DATA: begin
          if (stb_s) begin
            if (bit_cnt_r == LAST_DATA) begin
              bit_cnt_r <= 3'd0;
              if (HAS_PARITY) begin
                state_r <= txuart_pkg::PARITY;
                tx_r    <= par_r;
              end else begin
                state_r <= STOP;
                tx_r    <= 1'b1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
            end
          end
        end
        txuart_pkg::PARITY: begin
          if (stb_s) begin
            state_r   <= STOP;
            tx_r      <= 1'b1;
            bit_cnt_r <= 3'd0;
          end
        end
        STOP: begin
          if (stb_s) begin
            if (bit_cnt_r == LAST_STOP) begin
              state_r <= IDLE;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
`ifdef TXUART_BREAK_EN
        // Mark-after-break reuses STOP so its length tracks STOP_BITS.
        BREAK: begin
          if (!break_req_s) begin
            state_r   <= STOP;
            tx_r      <= 1'b1;
            bit_cnt_r <= 3'd0;
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign o_busy    = busy_s;
  assign o_uart_tx = tx_r;

endmodule

// File: tb/tb_txuart_cfg.sv
`timescale 1ns/1ps
module tb_txuart_cfg;

  logic       clk = 1'b0;
  logic       rst;
  int         n_tests = 0;
  int         n_fail  = 0;

  // Instance A: 16 clocks/bit, 8E1
  logic       wr_a;
  logic [7:0] data_a;
  logic       cts_a;
  logic       busy_a;
  logic       tx_a;
  // Instance B: 16 clocks/bit, 7O2
  logic       wr_b;
  logic [6:0] data_b;
  logic       cts_b;
  logic       busy_b;
  logic       tx_b;
`ifdef TXUART_BREAK_EN
  logic       brk_a;
  logic       brk_b;
`endif

  always #5 clk = ~clk;

  txuart_cfg #(.CLOCKS_PER_BAUD(24'd16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_wr(wr_a), .i_data(data_a), .i_cts_n(cts_a),
`ifdef TXUART_BREAK_EN
    .i_break(brk_a),
`endif
    .o_busy(busy_a), .o_uart_tx(tx_a)
  );

  txuart_cfg #(.CLOCKS_PER_BAUD(24'd16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_wr(wr_b), .i_data(data_b), .i_cts_n(cts_b),
`ifdef TXUART_BREAK_EN
    .i_break(brk_b),
`endif
    .o_busy(busy_b), .o_uart_tx(tx_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int errs;
    rst = 1'b1; wr_a = 1'b0; wr_b = 1'b0; data_a = 8'h00; data_b = 7'h00;
    cts_a = 1'b0; cts_b = 1'b0;
`ifdef TXUART_BREAK_EN
    brk_a = 1'b0; brk_b = 1'b0;
`endif
    repeat (3) tick();
    n_tests++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_a: tx=%b busy=%b expected tx=1 busy=0", tx_a, busy_a);
    end
    n_tests++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_b: tx=%b busy=%b expected tx=1 busy=0", tx_b, busy_b);
    end
    rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || tx_b !== 1'b1 || busy_b !== 1'b0) errs++;
    end
    n_tests++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL idle_500: %0d bad cycles, expected 0", errs);
    end
  endtask

  task automatic test_frame_8e1();
    logic [10:0] fr;
    int          bit_errs;
    int          busy_errs;
    int          idle_errs;
    fr = 11'b1_0_01010101_0;   // stop, parity 0, 0x55, start
    data_a = 8'h55; wr_a = 1'b1;
    tick();
    wr_a = 1'b0;
    n_tests++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL latency_8e1: tx=%b busy=%b expected tx=0 busy=1", tx_a, busy_a);
    end
    bit_errs = 0; busy_errs = 0;
    for (int c = 0; c < 176; c++) begin
      if (tx_a !== fr[c/16]) bit_errs++;
      if (busy_a !== ((c != 175) ? 1'b1 : 1'b0)) busy_errs++;
      // A write while busy must be ignored with no re-sample of data.
      if (c == 50) begin data_a = 8'hFF; wr_a = 1'b1; end
      if (c == 51) begin wr_a = 1'b0; data_a = 8'h00; end
      if (c < 175) tick();
    end
    n_tests++;
    if (bit_errs !== 0) begin
      n_fail++; $display("FAIL frame_8e1_0x55: %0d bad bit cycles, expected 0", bit_errs);
    end
    n_tests++;
    if (busy_errs !== 0) begin
      n_fail++; $display("FAIL busy_8e1: %0d bad busy cycles, expected 0", busy_errs);
    end
    idle_errs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tx_a !== 1'b1 || busy_a !== 1'b0) idle_errs++;
    end
    n_tests++;
    if (idle_errs !== 0) begin
      n_fail++; $display("FAIL ignore_wr_busy: %0d bad idle cycles, expected 0", idle_errs);
    end
  endtask

  task automatic test_back_to_back_7o2();
    logic [10:0] fr [3];
    logic [6:0]  dv [3];
    int          errs;
    fr[0] = 11'b1_1_1_0000011_0;  dv[0] = 7'h03;  // odd parity -> 1
    fr[1] = 11'b1_1_0_1111111_0;  dv[1] = 7'h7F;  // odd parity -> 0
    fr[2] = 11'b1_1_1_0000000_0;  dv[2] = 7'h00;  // odd parity -> 1
    data_b = dv[0]; wr_b = 1'b1;
    tick();
    wr_b = 1'b0;
    for (int f = 0; f < 3; f++) begin
      errs = 0;
      for (int c = 0; c < 176; c++) begin
        if (tx_b !== fr[f][c/16]) errs++;
        if (busy_b !== ((c != 175) ? 1'b1 : 1'b0)) errs++;
        if (c == 175 && f < 2) begin data_b = dv[f+1]; wr_b = 1'b1; end
        tick();
        wr_b = 1'b0;
      end
      n_tests++;
      if (errs !== 0) begin
        n_fail++; $display("FAIL frame_7o2_%0d: %0d bad cycles, expected 0", f, errs);
      end
    end
    n_tests++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_b2b: tx=%b busy=%b expected tx=1 busy=0", tx_b, busy_b);
    end
  endtask

  task automatic test_cts();
    logic [10:0] fr;
    int          errs;
    int          lat;
    fr = 11'b1_0_10100101_0;     // stop, even parity 0, 0xA5, start
    cts_a = 1'b1;
    repeat (4) tick();
    data_a = 8'hA5; wr_a = 1'b1;
    tick();
    wr_a = 1'b0;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      if (tx_a !== 1'b1 || busy_a !== 1'b1) errs++;
      tick();
    end
    n_tests++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL cts_hold: %0d bad cycles, expected 0", errs);
    end
    cts_a = 1'b0;
    lat = 0;
    while (tx_a !== 1'b0 && lat < 8) begin
      tick();
      lat++;
    end
    n_tests++;
    if (lat < 2 || lat > 3) begin
      n_fail++; $display("FAIL cts_latency: got %0d cycles, expected 2..3", lat);
    end
    errs = 0;
    for (int c = 0; c < 176; c++) begin
      if (tx_a !== fr[c/16]) errs++;
      if (busy_a !== ((c != 175) ? 1'b1 : 1'b0)) errs++;
      if (c == 40) cts_a = 1'b1;
      tick();
    end
    n_tests++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL cts_midframe: %0d bad cycles, expected 0", errs);
    end
    cts_a = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_midframe();
    logic [10:0] fr;
    int          errs;
    fr = 11'b1_0_00000000_0;
    data_a = 8'h00; wr_a = 1'b1;
    tick();
    wr_a = 1'b0;
    repeat (69) tick();
    n_tests++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_bit4: tx=%b busy=%b expected tx=0 busy=1", tx_a, busy_a);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: tx=%b busy=%b expected tx=1 busy=0", tx_a, busy_a);
    end
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    data_a = 8'h00; wr_a = 1'b1;
    tick();
    wr_a = 1'b0;
    errs = 0;
    for (int c = 0; c < 176; c++) begin
      if (tx_a !== fr[c/16]) errs++;
      if (busy_a !== ((c != 175) ? 1'b1 : 1'b0)) errs++;
      tick();
    end
    n_tests++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL post_reset_frame: %0d bad cycles, expected 0", errs);
    end
  endtask

`ifdef TXUART_BREAK_EN
  task automatic test_break();
    int errs;
    brk_a = 1'b1; data_a = 8'h3C; wr_a = 1'b1;
    tick();
    wr_a = 1'b0;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx_a !== 1'b0 || busy_a !== 1'b1) errs++;
      if (i == 299) brk_a = 1'b0;
      tick();
    end
    n_tests++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL break_low: %0d bad cycles, expected 0", errs);
    end
    errs = 0;
    for (int m = 0; m < 16; m++) begin
      if (tx_a !== 1'b1 || busy_a !== ((m != 15) ? 1'b1 : 1'b0)) errs++;
      tick();
    end
    n_tests++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL mark_after_break: %0d bad cycles, expected 0", errs);
    end
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      if (tx_a !== 1'b1 || busy_a !== 1'b0) errs++;
      tick();
    end
    n_tests++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL break_drops_wr: %0d bad cycles, expected 0", errs);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_8e1();
    test_back_to_back_7o2();
    test_cts();
    test_reset_midframe();
`ifdef TXUART_BREAK_EN
    test_break();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
